// File: rtl/cg_lane_reg.sv
// Lane-gated data register: per-lane load enables with optional data-change gating,
// a registered idle (SLEEP) indication and a saturating lane-load counter.
module cg_lane_reg #(
  parameter int WIDTH       = 32,
  parameter int LANES       = 4,
  parameter int DATA_GATE   = 1,
  parameter int IDLE_CYCLES = 4,
  parameter int CNT_W       = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [LANES-1:0] EN,
  input  logic [WIDTH-1:0] D_IN,
  input  logic             CLR_CNT,
  output logic [WIDTH-1:0] D_OUT,
  output logic [LANES-1:0] GATE_EN,
  output logic             SLEEP,
  output logic [CNT_W-1:0] UPD_CNT
);

  localparam int LW = WIDTH / LANES;
  localparam int IW = $clog2(IDLE_CYCLES + 1);
  localparam int PW = $clog2(LANES + 1);
  localparam int SW = CNT_W + PW;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  if (WIDTH % LANES != 0) begin : g_bad_width
    $error("cg_lane_reg: WIDTH must be a multiple of LANES");
  end
  if (IDLE_CYCLES < 1 || IDLE_CYCLES > 255) begin : g_bad_idle
    $error("cg_lane_reg: IDLE_CYCLES must be in 1..255");
  end

  typedef enum logic {ST_ACTIVE, ST_SLEEPING} state_t;

  logic [WIDTH-1:0] d_q;
  logic [LANES-1:0] gate;
  logic [PW-1:0]    pop;
  logic             any_load;
  logic [IW-1:0]    idle_cnt;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_nxt;
  logic [SW-1:0]    cnt_sum;
  state_t           state_q;
  state_t           state_d;

  // Per-lane ICG enable; with data gating a lane whose value would not change stays gated.
  always_comb begin
    gate = '0;
    for (int i = 0; i < LANES; i++) begin
      if (DATA_GATE != 0) gate[i] = EN[i] & (D_IN[i*LW +: LW] != d_q[i*LW +: LW]);
      else                gate[i] = EN[i];
    end
  end

  always_comb begin
    pop = '0;
    for (int i = 0; i < LANES; i++) pop = pop + PW'(gate[i]);
  end

  assign any_load = |gate;

  always_ff @(posedge CLK) begin
    if (RST) begin
      d_q <= '0;
    end else begin
      for (int i = 0; i < LANES; i++) begin
        if (gate[i]) d_q[i*LW +: LW] <= D_IN[i*LW +: LW];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST)                                   idle_cnt <= '0;
    else if (any_load)                         idle_cnt <= '0;
    else if (idle_cnt < IW'(IDLE_CYCLES))      idle_cnt <= idle_cnt + IW'(1);
  end

  // Sleep FSM: state register
  always_ff @(posedge CLK) begin
    if (RST) state_q <= ST_ACTIVE;
    else     state_q <= state_d;
  end

  // Sleep FSM: next state; sleep is entered on the edge the idle count reaches IDLE_CYCLES
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_ACTIVE:   if (!any_load && idle_cnt == IW'(IDLE_CYCLES - 1)) state_d = ST_SLEEPING;
      ST_SLEEPING: if (any_load) state_d = ST_ACTIVE;
      default:     state_d = ST_ACTIVE;
    endcase
  end

  // Sleep FSM: outputs
  always_comb begin
    SLEEP = (state_q == ST_SLEEPING);
  end

  assign cnt_sum = SW'(cnt_q) + SW'(pop);
  assign cnt_nxt = (cnt_sum > SW'(CNT_MAX)) ? CNT_MAX : cnt_sum[CNT_W-1:0];

  // Clear takes priority over the same cycle's increment.
  always_ff @(posedge CLK) begin
    if (RST)          cnt_q <= '0;
    else if (CLR_CNT) cnt_q <= '0;
    else              cnt_q <= cnt_nxt;
  end

  assign D_OUT   = d_q;
  assign GATE_EN = gate;
  assign UPD_CNT = cnt_q;

endmodule

// File: tb/tb_cg_lane_reg.sv
// Bench for cg_lane_reg: three parameterisations driven with identical stimulus,
// each checked against a lane-level reference model through a scoreboard queue.
module tb_cg_lane_reg;

  localparam int NDUT = 3;

  typedef struct packed {
    logic [3:0]  gate;
    logic [31:0] dout;
    logic        sleep;
    logic [15:0] cnt;
  } exp_t;
  localparam int EW = $bits(exp_t);

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [3:0]  EN = '0;
  logic [31:0] D_IN = '0;
  logic        CLR_CNT = 1'b0;

  logic [31:0] d_out0, d_out1, d_out2;
  logic [3:0]  gate0, gate1, gate2;
  logic        sleep0, sleep1, sleep2;
  logic [15:0] cnt0, cnt1;
  logic [3:0]  cnt2;

  int n_tests = 0;
  int n_fail  = 0;

  logic [NDUT*EW-1:0] exp_q[$];

  // reference model state: lane data, run length of no-load edges, load count
  logic [31:0] m_dout[NDUT];
  int          m_run[NDUT];
  int          m_cnt[NDUT];
  int          m_dg[NDUT]   = '{1, 0, 1};
  int          m_idle[NDUT] = '{4, 4, 2};
  int          m_max[NDUT]  = '{65535, 65535, 15};

  always #5 CLK = ~CLK;

  cg_lane_reg u_dut0 (
    .CLK(CLK), .RST(RST), .EN(EN), .D_IN(D_IN), .CLR_CNT(CLR_CNT),
    .D_OUT(d_out0), .GATE_EN(gate0), .SLEEP(sleep0), .UPD_CNT(cnt0)
  );

  cg_lane_reg #(.DATA_GATE(0)) u_dut1 (
    .CLK(CLK), .RST(RST), .EN(EN), .D_IN(D_IN), .CLR_CNT(CLR_CNT),
    .D_OUT(d_out1), .GATE_EN(gate1), .SLEEP(sleep1), .UPD_CNT(cnt1)
  );

  cg_lane_reg #(.IDLE_CYCLES(2), .CNT_W(4)) u_dut2 (
    .CLK(CLK), .RST(RST), .EN(EN), .D_IN(D_IN), .CLR_CNT(CLR_CNT),
    .D_OUT(d_out2), .GATE_EN(gate2), .SLEEP(sleep2), .UPD_CNT(cnt2)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_step(input int k, output exp_t e);
    logic [3:0] g;
    int n;
    g = '0;
    n = 0;
    for (int i = 0; i < 4; i++) begin
      if (EN[i] && (m_dg[k] == 0 || D_IN[i*8 +: 8] != m_dout[k][i*8 +: 8])) begin
        g[i] = 1'b1;
        n++;
      end
    end
    if (RST) begin
      m_dout[k] = '0;
      m_run[k]  = 0;
      m_cnt[k]  = 0;
    end else begin
      for (int i = 0; i < 4; i++) if (g[i]) m_dout[k][i*8 +: 8] = D_IN[i*8 +: 8];
      m_run[k] = (n > 0) ? 0 : ((m_run[k] < 1000) ? m_run[k] + 1 : m_run[k]);
      if (CLR_CNT) m_cnt[k] = 0;
      else         m_cnt[k] = (m_cnt[k] + n > m_max[k]) ? m_max[k] : m_cnt[k] + n;
    end
    e.gate  = g;
    e.dout  = m_dout[k];
    e.sleep = (m_run[k] >= m_idle[k]);
    e.cnt   = m_cnt[k][15:0];
  endtask

  // driver: apply one cycle of inputs at the falling edge and log what the next rising edge must produce
  task automatic step(input logic rst, input logic [3:0] en, input logic [31:0] din,
                      input logic clr, input bit push);
    exp_t e0, e1, e2;
    @(negedge CLK);
    RST = rst; EN = en; D_IN = din; CLR_CNT = clr;
    model_step(0, e0);
    model_step(1, e1);
    model_step(2, e2);
    if (push) exp_q.push_back({e0, e1, e2});
  endtask

  task automatic settle();
    @(posedge CLK);
    #2;
  endtask

  // monitor: GATE_EN sampled before the edge, registered outputs just after it
  initial begin
    logic [3:0] gs[NDUT];
    logic [NDUT*EW-1:0] cur;
    exp_t e;
    forever begin
      @(negedge CLK);
      #3;
      gs[0] = gate0; gs[1] = gate1; gs[2] = gate2;
      @(posedge CLK);
      #1;
      if (exp_q.size() > 0) begin
        cur = exp_q.pop_front();
        for (int k = 0; k < NDUT; k++) begin
          e = exp_t'(cur[(NDUT-1-k)*EW +: EW]);
          chk($sformatf("dut%0d_gate_en", k), 64'(gs[k]), 64'(e.gate));
          case (k)
            0: begin
              chk("dut0_d_out", 64'(d_out0), 64'(e.dout));
              chk("dut0_sleep", 64'(sleep0), 64'(e.sleep));
              chk("dut0_upd_cnt", 64'(cnt0), 64'(e.cnt));
            end
            1: begin
              chk("dut1_d_out", 64'(d_out1), 64'(e.dout));
              chk("dut1_sleep", 64'(sleep1), 64'(e.sleep));
              chk("dut1_upd_cnt", 64'(cnt1), 64'(e.cnt));
            end
            default: begin
              chk("dut2_d_out", 64'(d_out2), 64'(e.dout));
              chk("dut2_sleep", 64'(sleep2), 64'(e.sleep));
              chk("dut2_upd_cnt", 64'(cnt2), 64'(e.cnt));
            end
          endcase
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int burst;
    logic [3:0]  r_en;
    logic [31:0] r_din;
    for (int k = 0; k < NDUT; k++) begin
      m_dout[k] = '0; m_run[k] = 0; m_cnt[k] = 0;
    end
    burst = 0;

    step(1'b1, 4'hF, 32'hFFFF_FFFF, 1'b0, 1'b0);
    step(1'b1, 4'hF, 32'hFFFF_FFFF, 1'b0, 1'b1);
    settle();
    chk("reset_d_out", 64'(d_out0), 64'h0);
    chk("reset_sleep", 64'(sleep0), 64'h0);
    chk("reset_upd_cnt", 64'(cnt0), 64'h0);

    step(1'b0, 4'hF, 32'h1, 1'b0, 1'b1);
    #1 chk("dg_first_gate", 64'(gate0), 64'h1);
    settle();
    chk("dg_first_d_out", 64'(d_out0), 64'h1);
    chk("dg_first_cnt", 64'(cnt0), 64'h1);

    step(1'b0, 4'hF, 32'h1, 1'b0, 1'b1);
    #1 chk("dg_same_gate", 64'(gate0), 64'h0);
    chk("nodg_same_gate", 64'(gate1), 64'hF);
    settle();
    chk("dg_same_d_out", 64'(d_out0), 64'h1);
    chk("dg_same_cnt", 64'(cnt0), 64'h1);
    chk("nodg_cnt", 64'(cnt1), 64'd8);
    chk("nodg_sleep", 64'(sleep1), 64'h0);

    step(1'b0, 4'b0101, 32'hAABB_CCDD, 1'b0, 1'b1);
    settle();
    chk("partial_d_out", 64'(d_out0), 64'h00BB_00DD);
    chk("partial_cnt", 64'(cnt0), 64'd3);

    for (int i = 0; i < 4; i++) begin
      step(1'b0, 4'h0, 32'hAABB_CCDD, 1'b0, 1'b1);
      settle();
      chk($sformatf("idle_sleep_%0d", i), 64'(sleep0), (i == 3) ? 64'h1 : 64'h0);
    end

    step(1'b0, 4'h1, 32'h00BB_0011, 1'b0, 1'b1);
    settle();
    chk("wake_sleep", 64'(sleep0), 64'h0);
    chk("wake_d_out", 64'(d_out0), 64'h00BB_0011);

    step(1'b1, 4'h0, 32'h0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 4'hF, (i % 2 == 0) ? 32'hFFFF_FFFF : 32'h0, 1'b0, 1'b1);
      settle();
      chk($sformatf("sat_cnt_%0d", i), 64'(cnt2), (i < 3) ? 64'(4 * (i + 1)) : 64'd15);
    end
    step(1'b0, 4'hF, 32'h0, 1'b1, 1'b1);
    settle();
    chk("clr_cnt", 64'(cnt2), 64'h0);
    chk("clr_d_out", 64'(d_out2), 64'h0);

    for (int c = 0; c < 400; c++) begin
      if (burst > 0) begin
        r_en = 4'h0;
        burst--;
      end else begin
        if ($urandom_range(0, 19) == 0) burst = $urandom_range(1, 6);
        r_en = 4'($urandom_range(0, 15));
      end
      for (int i = 0; i < 4; i++) begin
        if ($urandom_range(0, 1) == 0) r_din[i*8 +: 8] = m_dout[0][i*8 +: 8];
        else                           r_din[i*8 +: 8] = 8'($urandom_range(0, 255));
      end
      step(($urandom_range(0, 63) == 0), r_en, r_din, ($urandom_range(0, 15) == 0), 1'b1);
    end

    repeat (3) @(negedge CLK);
    chk("queue_drained", 64'(exp_q.size()), 64'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cg_lane_reg.md
Name: cg_lane_reg

Overview:
- Parametrised, clock-gating-aware data register: the next generation of the single-enable 32-bit gated register.
- Register is split into independently enabled byte-style lanes.
- Optional data-driven gating: a lane only loads when its data actually changes.
- Provides an idle detector (SLEEP) and a saturating lane-update counter for power estimation. Sits in front of datapath registers that are targeted by the clock-gating flow.

Parameters:
- WIDTH, 32, total data width; must be a multiple of LANES.
- LANES, 4, number of independently gated lanes; LW = WIDTH/LANES.
- DATA_GATE, 1, 1: lane load requires EN and changed data; 0: lane load requires EN only.
- IDLE_CYCLES, 4, consecutive no-load cycles before SLEEP asserts; range 1..255.
- CNT_W, 16, width of the update counter.

Ports:
- CLK, input, 1, sole clock; all state updates on the rising edge.
- RST, input, 1, synchronous reset, active-high.
- EN, input, LANES, per-lane enable; lane i covers D_IN[i*LW +: LW].
- D_IN, input, WIDTH, write data.
- CLR_CNT, input, 1, synchronous clear of UPD_CNT.
- D_OUT, output, WIDTH, registered data.
- GATE_EN, output, LANES, combinational per-lane clock-enable (the ICG enable term).
- SLEEP, output, 1, registered idle indication.
- UPD_CNT, output, CNT_W, saturating count of lane loads.

Behaviour:
- Interface: one clock (CLK); reset RST is synchronous and active-high.
- Reset: on a rising CLK edge with RST=1, D_OUT=0, SLEEP=0, UPD_CNT=0, idle counter=0. RST overrides EN, D_IN and CLR_CNT. Reset asserted mid-activity discards any pending load.
- GATE_EN[i] is combinational:
  - DATA_GATE=1: EN[i] & (D_IN lane i != D_OUT lane i).
  - DATA_GATE=0: EN[i].
- Load: at a rising edge with RST=0, each lane with GATE_EN[i]=1 captures its D_IN slice. Lanes with GATE_EN[i]=0 hold.
- Latency: D_OUT reflects D_IN one edge after sampling. No combinational path from D_IN to D_OUT.
- any_load = |GATE_EN.
- Idle counter (width ceil(log2(IDLE_CYCLES+1))):
  - any_load=1 -> counter=0, SLEEP=0 on that edge.
  - else if counter<IDLE_CYCLES -> counter+1.
  - SLEEP becomes 1 on the edge where the counter reaches IDLE_CYCLES, and holds while idle.
- SLEEP states:
  - ACTIVE (SLEEP=0): transitions to SLEEPING after IDLE_CYCLES consecutive no-load edges.
  - SLEEPING (SLEEP=1): transitions to ACTIVE on the first load edge (wake takes effect the same edge the data loads).
- EN=1 with unchanged data (DATA_GATE=1) produces no load and counts as idle.
- UPD_CNT:
  - Each non-reset edge adds popcount(GATE_EN).
  - Saturates at 2^CNT_W-1; never wraps.
  - CLR_CNT=1 sets it to 0 and drops that cycle's increment (clear wins over a simultaneous update).
- Elaboration error if WIDTH % LANES != 0 or IDLE_CYCLES == 0.

Test Plan:
- Reset: RST=1 for 2 edges with EN=4'hF, D_IN=32'hFFFF_FFFF -> D_OUT=0, SLEEP=0, UPD_CNT=0.
- Data gating: from reset, D_IN=32'h1, EN=4'hF -> before edge GATE_EN=4'b0001; after edge D_OUT=32'h1, UPD_CNT=1. Re-apply the same inputs -> GATE_EN=0, D_OUT unchanged, UPD_CNT=1.
- Partial lanes: D_OUT=32'h1, D_IN=32'hAABB_CCDD, EN=4'b0101 -> D_OUT=32'h00BB_00DD, UPD_CNT increases by 2.
- Idle/wake: EN=0 for 3 edges -> SLEEP=0; 4th edge -> SLEEP=1. Then EN=4'h1 with D_IN lane0 != D_OUT lane0 -> after next edge SLEEP=0 and lane0 updated.
- DATA_GATE=0 instance: EN=4'hF, D_IN equal to D_OUT -> GATE_EN=4'hF, UPD_CNT increases by 4, SLEEP stays 0.
- Saturation/clear (CNT_W=4): alternate D_IN 32'h0 / 32'hFFFF_FFFF with EN=4'hF for 5 edges -> UPD_CNT stops at 15. CLR_CNT=1 on an edge with a 4-lane load -> UPD_CNT=0 and D_OUT still loads.
